// File: rtl/serial_link_pkg.sv
// ---------------------------------------------------------------------------
// serial_link_pkg
// Shared definitions for both ends of the load/shift serial link (the
// serializer and deserialize_4bit).
//
// Contents:
//    linkState_e      - frame FSM states (IDLE, SHIFT, PARITY)
//    MSB_FIRST        - bit order on the wire (1 = most significant bit first)
//    DEFAULT_WIDTH    - default number of data bits per frame
//    PARITY_EVEN      - value that XOR(word, parity bit) takes for even parity
//    PARITY_POLARITY  - polarity the link actually uses (even)
// ---------------------------------------------------------------------------
package serial_link_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } linkState_e;

   localparam bit   MSB_FIRST       = 1'b1;
   localparam int   DEFAULT_WIDTH   = 4;
   localparam logic PARITY_EVEN     = 1'b0;
   localparam logic PARITY_POLARITY = PARITY_EVEN;

endpackage : serial_link_pkg

// File: rtl/sipo_shift_reg.sv
// ---------------------------------------------------------------------------
// sipo_shift_reg
// Serial-in / parallel-out shift register used by the link receiver.
// New bits enter at the end selected by the link bit order, so with
// MSB-first the first bit received ends up in the MSB of the word.
//
// Ports:
//    clk_i       - clock, rising edge
//    rst_ni      - asynchronous active-low reset, clears the register
//    clear_i     - synchronous clear (takes priority over shift)
//    shift_en_i  - shift serial_i into the register this edge
//    serial_i    - serial data bit
//    parallel_o  - current register contents
// ---------------------------------------------------------------------------
module sipo_shift_reg
   import serial_link_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             shift_en_i,
   input  logic             serial_i,
   output logic [WIDTH-1:0] parallel_o
);

   logic [WIDTH-1:0] shiftReg_q;

   // Clear wins over shift so that a frame marker always starts from an
   // empty register, even if the FSM were to request both at once.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shiftReg_q <= '0;
      end else if (clear_i) begin
         shiftReg_q <= '0;
      end else if (shift_en_i) begin
         if (MSB_FIRST) begin
            shiftReg_q <= {shiftReg_q[WIDTH-2:0], serial_i};
         end else begin
            shiftReg_q <= {serial_i, shiftReg_q[WIDTH-1:1]};
         end
      end
   end

   assign parallel_o = shiftReg_q;

endmodule : sipo_shift_reg

// File: rtl/deserialize_4bit.sv
// ---------------------------------------------------------------------------
// deserialize_4bit
// Receiving end of the load/shift serial link. A one-cycle frame marker
// starts a frame; WIDTH data bits follow (MSB first), optionally followed
// by one even-parity bit. A good word is registered on data_out with a
// one-cycle valid strobe. A marker arriving mid-frame aborts the frame
// (frame_err strobe) and starts a new one; a bad parity bit drops the word
// (parity_err strobe).
//
// Parameters:
//    WIDTH      - data bits per frame (2..16)
//    PARITY_EN  - 1 adds an even-parity bit after the data bits
//
// Ports:
//    input_clock1_clk_1            - clock, rising edge
//    input_push_button1_reset_n_2  - asynchronous active-low reset
//    input_serial_in_3             - serial data, MSB first
//    input_load_shift_4            - frame marker, one cycle before a frame
//    output_data_out_5             - last good word, registered
//    output_valid_6                - strobe: data_out updated this cycle
//    output_busy_7                 - frame in progress
//    output_frame_err_8            - strobe: frame aborted by a marker
//    output_parity_err_9           - strobe: parity mismatch, word dropped
// ---------------------------------------------------------------------------
module deserialize_4bit
   import serial_link_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit PARITY_EN = 1'b0
) (
   input  logic             input_clock1_clk_1,
   input  logic             input_push_button1_reset_n_2,
   input  logic             input_serial_in_3,
   input  logic             input_load_shift_4,
   output logic [WIDTH-1:0] output_data_out_5,
   output logic             output_valid_6,
   output logic             output_busy_7,
   output logic             output_frame_err_8,
   output logic             output_parity_err_9
);

   localparam int CntW = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

   linkState_e       state_q, state_d;
   logic [CntW-1:0]  bitCnt_q, bitCnt_d;
   logic [WIDTH-1:0] dataOut_q, dataOut_d;
   logic             valid_q, valid_d;
   logic             frameErr_q, frameErr_d;
   logic             parityErr_q, parityErr_d;

   logic             srClear;
   logic             srShift;
   logic [WIDTH-1:0] srWord;
   logic [WIDTH-1:0] assembledWord;
   logic             parityOk;

   sipo_shift_reg #(
      .WIDTH(WIDTH)
   ) uShiftReg (
      .clk_i      (input_clock1_clk_1),
      .rst_ni     (input_push_button1_reset_n_2),
      .clear_i    (srClear),
      .shift_en_i (srShift),
      .serial_i   (input_serial_in_3),
      .parallel_o (srWord)
   );

   // Without parity the word is published on the same edge that samples
   // its last bit, so it has to be formed from the register plus the bit
   // currently on the line rather than from the register alone.
   assign assembledWord = MSB_FIRST ? {srWord[WIDTH-2:0], input_serial_in_3}
                                    : {input_serial_in_3, srWord[WIDTH-1:1]};

   // In PARITY the register already holds the complete word; the bit on the
   // line is the parity bit.
   assign parityOk = ((^srWord) ^ input_serial_in_3) == PARITY_POLARITY;

   // Next-state logic. A marker seen in SHIFT or PARITY is both an abort of
   // the current frame and the start of the next one, so it restarts the
   // counter and register and lands in SHIFT. The counter stops at its last
   // value because reaching it always forces a state change.
   always_comb begin
      state_d     = state_q;
      bitCnt_d    = bitCnt_q;
      dataOut_d   = dataOut_q;
      valid_d     = 1'b0;
      frameErr_d  = 1'b0;
      parityErr_d = 1'b0;
      srClear     = 1'b0;
      srShift     = 1'b0;

      case (state_q)
         IDLE: begin
            if (input_load_shift_4) begin
               state_d  = SHIFT;
               bitCnt_d = '0;
               srClear  = 1'b1;
            end
         end

         SHIFT: begin
            if (input_load_shift_4) begin
               frameErr_d = 1'b1;
               bitCnt_d   = '0;
               srClear    = 1'b1;
            end else begin
               srShift  = 1'b1;
               bitCnt_d = bitCnt_q + 1'b1;
               if (bitCnt_q == LastBit) begin
                  if (PARITY_EN) begin
                     state_d = PARITY;
                  end else begin
                     dataOut_d = assembledWord;
                     valid_d   = 1'b1;
                     state_d   = IDLE;
                  end
               end
            end
         end

         PARITY: begin
            if (input_load_shift_4) begin
               frameErr_d = 1'b1;
               bitCnt_d   = '0;
               srClear    = 1'b1;
               state_d    = SHIFT;
            end else begin
               state_d = IDLE;
               if (parityOk) begin
                  dataOut_d = srWord;
                  valid_d   = 1'b1;
               end else begin
                  parityErr_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // All state and all outputs are registered; reset drops everything at
   // once, including any partial frame, without raising a strobe.
   always_ff @(posedge input_clock1_clk_1 or negedge input_push_button1_reset_n_2) begin
      if (!input_push_button1_reset_n_2) begin
         state_q     <= IDLE;
         bitCnt_q    <= '0;
         dataOut_q   <= '0;
         valid_q     <= 1'b0;
         frameErr_q  <= 1'b0;
         parityErr_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bitCnt_q    <= bitCnt_d;
         dataOut_q   <= dataOut_d;
         valid_q     <= valid_d;
         frameErr_q  <= frameErr_d;
         parityErr_q <= parityErr_d;
      end
   end

   assign output_data_out_5   = dataOut_q;
   assign output_valid_6      = valid_q;
   assign output_busy_7       = (state_q == SHIFT) || (state_q == PARITY);
   assign output_frame_err_8  = frameErr_q;
   assign output_parity_err_9 = parityErr_q;

endmodule : deserialize_4bit

// File: tb/tb_deserialize_4bit.sv
// ---------------------------------------------------------------------------
// tb_deserialize_4bit
// Self-checking bench for deserialize_4bit. Two instances share clock and
// reset: dutA (WIDTH=4, no parity) and dutB (WIDTH=4, even parity).
// ---------------------------------------------------------------------------
module tb_deserialize_4bit;

   typedef struct {
      logic       marker;
      logic       serial;
      logic [3:0] expData;
      logic       expValid;
      logic       expBusy;
      logic       expFrameErr;
   } vec_t;

   logic       clk;
   logic       rstN;

   logic       markerA, serialA;
   logic [3:0] dataA;
   logic       validA, busyA, frameErrA, parityErrA;

   logic       markerB, serialB;
   logic [3:0] dataB;
   logic       validB, busyB, frameErrB, parityErrB;

   int         checkCount;
   int         errorCount;
   vec_t       vecs[$];

   deserialize_4bit #(
      .WIDTH(4),
      .PARITY_EN(1'b0)
   ) dutA (
      .input_clock1_clk_1           (clk),
      .input_push_button1_reset_n_2 (rstN),
      .input_serial_in_3            (serialA),
      .input_load_shift_4           (markerA),
      .output_data_out_5            (dataA),
      .output_valid_6               (validA),
      .output_busy_7                (busyA),
      .output_frame_err_8           (frameErrA),
      .output_parity_err_9          (parityErrA)
   );

   deserialize_4bit #(
      .WIDTH(4),
      .PARITY_EN(1'b1)
   ) dutB (
      .input_clock1_clk_1           (clk),
      .input_push_button1_reset_n_2 (rstN),
      .input_serial_in_3            (serialB),
      .input_load_shift_4           (markerB),
      .output_data_out_5            (dataB),
      .output_valid_6               (validB),
      .output_busy_7                (busyB),
      .output_frame_err_8           (frameErrB),
      .output_parity_err_9          (parityErrB)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One field comparison; every check in the bench goes through here.
   task automatic compareField(input string tag, input string field,
                               input logic [3:0] act, input logic [3:0] exp);
      checkCount++;
      if (act !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s.%s: got %h, expected %h", tag, field, act, exp);
      end
   endtask

   // Compare all outputs of the selected DUT (0 = dutA, 1 = dutB).
   task automatic checkOutput(input int dutSel, input string tag,
                              input logic [3:0] expData, input logic expValid,
                              input logic expBusy, input logic expFrameErr,
                              input logic expParityErr);
      if (dutSel == 0) begin
         compareField(tag, "data",      dataA,             expData);
         compareField(tag, "valid",     {3'b0, validA},    {3'b0, expValid});
         compareField(tag, "busy",      {3'b0, busyA},     {3'b0, expBusy});
         compareField(tag, "frameErr",  {3'b0, frameErrA}, {3'b0, expFrameErr});
         compareField(tag, "parityErr", {3'b0, parityErrA},{3'b0, expParityErr});
      end else begin
         compareField(tag, "data",      dataB,             expData);
         compareField(tag, "valid",     {3'b0, validB},    {3'b0, expValid});
         compareField(tag, "busy",      {3'b0, busyB},     {3'b0, expBusy});
         compareField(tag, "frameErr",  {3'b0, frameErrB}, {3'b0, expFrameErr});
         compareField(tag, "parityErr", {3'b0, parityErrB},{3'b0, expParityErr});
      end
   endtask

   // Drive one cycle of marker/serial into the selected DUT at the falling
   // edge and return just after the rising edge that samples it.
   task automatic applyStimulus(input int dutSel, input logic marker, input logic serial);
      @(negedge clk);
      if (dutSel == 0) begin
         markerA = marker;
         serialA = serial;
         markerB = 1'b0;
      end else begin
         markerB = marker;
         serialB = serial;
         markerA = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic addVec(input logic marker, input logic serial, input logic [3:0] expData,
                         input logic expValid, input logic expBusy, input logic expFrameErr);
      vec_t v;
      v.marker      = marker;
      v.serial      = serial;
      v.expData     = expData;
      v.expValid    = expValid;
      v.expBusy     = expBusy;
      v.expFrameErr = expFrameErr;
      vecs.push_back(v);
   endtask

   // Full parity frame on dutB: marker, four data bits MSB first, parity bit.
   task automatic sendParityFrame(input string tag, input logic [3:0] word, input logic pbit,
                                  input logic [3:0] prevData, input logic [3:0] expData,
                                  input logic expValid, input logic expParityErr);
      logic [3:0] w;
      w = word;
      applyStimulus(1, 1'b1, 1'b0);
      checkOutput(1, {tag, "_mk"}, prevData, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 3; i >= 0; i--) begin
         applyStimulus(1, 1'b0, w[i]);
         checkOutput(1, $sformatf("%s_b%0d", tag, i), prevData, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      applyStimulus(1, 1'b0, pbit);
      checkOutput(1, {tag, "_par"}, expData, expValid, 1'b0, 1'b0, expParityErr);
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      markerA = 1'b0; serialA = 1'b0;
      markerB = 1'b0; serialB = 1'b0;
      rstN    = 1'b1;

      // ---- reset state ----
      #1 rstN = 1'b0;
      #2;
      checkOutput(0, "resetA", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput(1, "resetB", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      rstN = 1'b1;

      // ---- table: basic frame 1011 ----
      addVec(1, 0, 4'h0, 0, 1, 0);
      addVec(0, 1, 4'h0, 0, 1, 0);
      addVec(0, 0, 4'h0, 0, 1, 0);
      addVec(0, 1, 4'h0, 0, 1, 0);
      addVec(0, 1, 4'hB, 1, 0, 0);
      addVec(0, 0, 4'hB, 0, 0, 0);
      // ---- back-to-back 0xA then 0x5 (marker cycle carries serial=1) ----
      addVec(1, 1, 4'hB, 0, 1, 0);
      addVec(0, 1, 4'hB, 0, 1, 0);
      addVec(0, 0, 4'hB, 0, 1, 0);
      addVec(0, 1, 4'hB, 0, 1, 0);
      addVec(0, 0, 4'hA, 1, 0, 0);
      addVec(1, 0, 4'hA, 0, 1, 0);
      addVec(0, 0, 4'hA, 0, 1, 0);
      addVec(0, 1, 4'hA, 0, 1, 0);
      addVec(0, 0, 4'hA, 0, 1, 0);
      addVec(0, 1, 4'h5, 1, 0, 0);
      // ---- abort after two bits, then 0011 ----
      addVec(1, 0, 4'h5, 0, 1, 0);
      addVec(0, 1, 4'h5, 0, 1, 0);
      addVec(0, 1, 4'h5, 0, 1, 0);
      addVec(1, 1, 4'h5, 0, 1, 1);
      addVec(0, 0, 4'h5, 0, 1, 0);
      addVec(0, 0, 4'h5, 0, 1, 0);
      addVec(0, 1, 4'h5, 0, 1, 0);
      addVec(0, 1, 4'h3, 1, 0, 0);
      // ---- serial toggling in IDLE with no marker ----
      for (int i = 0; i < 20; i++) begin
         addVec(0, (i % 2 == 0) ? 1'b1 : 1'b0, 4'h3, 0, 0, 0);
      end

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(0, vecs[i].marker, vecs[i].serial);
         checkOutput(0, $sformatf("vec%0d", i), vecs[i].expData, vecs[i].expValid,
                     vecs[i].expBusy, vecs[i].expFrameErr, 1'b0);
      end

      // ---- parity: good then bad ----
      sendParityFrame("par7ok",  4'h7, 1'b1, 4'h0, 4'h7, 1'b1, 1'b0);
      sendParityFrame("par7bad", 4'h7, 1'b0, 4'h7, 4'h7, 1'b0, 1'b1);

      // ---- marker during the parity cycle aborts, then 0xC with parity 0 ----
      applyStimulus(1, 1'b1, 1'b0);
      applyStimulus(1, 1'b0, 1'b1);
      applyStimulus(1, 1'b0, 1'b0);
      applyStimulus(1, 1'b0, 1'b0);
      applyStimulus(1, 1'b0, 1'b0);
      checkOutput(1, "parWait", 4'h7, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1, 1'b1, 1'b1);
      checkOutput(1, "parAbort", 4'h7, 1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(1, 1'b0, 1'b1);
      applyStimulus(1, 1'b0, 1'b1);
      applyStimulus(1, 1'b0, 1'b0);
      applyStimulus(1, 1'b0, 1'b0);
      checkOutput(1, "parCBits", 4'h7, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1, 1'b0, 1'b0);
      checkOutput(1, "parC", 4'hC, 1'b1, 1'b0, 1'b0, 1'b0);

      // ---- asynchronous reset after two bits of a frame on dutA ----
      applyStimulus(0, 1'b1, 1'b0);
      applyStimulus(0, 1'b0, 1'b1);
      applyStimulus(0, 1'b0, 1'b1);
      checkOutput(0, "preRst", 4'h3, 1'b0, 1'b1, 1'b0, 1'b0);
      #2 rstN = 1'b0;
      #1;
      checkOutput(0, "midRstA", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput(1, "midRstB", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rstN = 1'b1;
      // Remaining bits with no fresh marker must not resume the frame.
      applyStimulus(0, 1'b0, 1'b0);
      applyStimulus(0, 1'b0, 1'b0);
      checkOutput(0, "postRstIdle", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(0, 1'b1, 1'b0);
      applyStimulus(0, 1'b0, 1'b1);
      applyStimulus(0, 1'b0, 1'b1);
      applyStimulus(0, 1'b0, 1'b0);
      checkOutput(0, "postRstBits", 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(0, 1'b0, 1'b0);
      checkOutput(0, "postRstC", 4'hC, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(0, 1'b0, 1'b1);
      checkOutput(0, "postRstHold", 4'hC, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule : tb_deserialize_4bit
